// File: rtl/round_robin_weighted_arbiter_n_input_1_output.sv
// Generic synchronous FIFO with occupancy count and a combinational head word.
// Latency: a pushed word is visible at the head on the cycle after its push edge.
// Backpressure: the owner must not push when full nor pop when empty.
module rr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
endmodule

// N-to-1 weighted round-robin arbiter with per-channel input FIFOs and a registered output.
// Latency: word pushed into an empty FIFO appears on out_valid two cycles after it is driven.
// Backpressure: out_ready low freezes the output word and all pops; full FIFOs drop in_ready.
module round_robin_weighted_arbiter_n_input_1_output #(
    parameter int NUM_REQUESTS = 4,
    parameter int WIDTH        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int CH_W        = $clog2(NUM_REQUESTS)
) (
    input  logic                                       clock,
    input  logic                                       rst,
    input  logic                                       enabled,
    input  logic [NUM_REQUESTS-1:0]                    in_valid,
    input  logic [NUM_REQUESTS-1:0][WIDTH-1:0]         in_data,
    output logic [NUM_REQUESTS-1:0]                    in_ready,
    input  logic [NUM_REQUESTS-1:0][WEIGHT_WIDTH-1:0]  weight,
    output logic                                       out_valid,
    output logic [WIDTH-1:0]                           out_data,
    output logic [CH_W-1:0]                            out_channel,
    input  logic                                       out_ready,
    output logic [NUM_REQUESTS-1:0]                    fifo_empty
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] dat;
    } out_word_t;

    state_t                  state;
    logic [CH_W-1:0]         ptr;
    logic [CH_W-1:0]         cur;
    logic [WEIGHT_WIDTH-1:0] remaining;
    out_word_t               out_q;

    logic [CNT_W-1:0]        count [NUM_REQUESTS];
    logic [WIDTH-1:0]        head  [NUM_REQUESTS];
    logic [NUM_REQUESTS-1:0] push;
    logic [NUM_REQUESTS-1:0] pop;

    logic                    slot_free;
    logic                    sel_vld;
    logic [CH_W-1:0]         sel;
    logic                    do_pop;
    logic [CH_W-1:0]         pop_ch;
    logic                    empties_after;
    logic [WEIGHT_WIDTH-1:0] first_rem;

    function automatic logic [CH_W-1:0] next_of(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_REQUESTS - 1)) ? '0 : c + 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_REQUESTS; i++) begin : g_ch
        assign in_ready[i]   = (count[i] < CNT_W'(FIFO_DEPTH)) & ~rst;
        assign push[i]       = in_valid[i] & in_ready[i];
        assign fifo_empty[i] = (count[i] == '0);
        assign pop[i]        = do_pop & (pop_ch == CH_W'(i));

        rr_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .rst       (rst),
            .push      (push[i]),
            .push_data (in_data[i]),
            .pop       (pop[i]),
            .head_data (head[i]),
            .count     (count[i])
        );
    end

    assign slot_free = ~out_valid | out_ready;

    // Scan from farthest to nearest so the last hit is the first non-empty channel at/after ptr.
    always_comb begin
        int t;
        sel     = ptr;
        sel_vld = 1'b0;
        t       = 0;
        for (int k = NUM_REQUESTS - 1; k >= 0; k--) begin
            t = int'(ptr) + k;
            if (t >= NUM_REQUESTS) t = t - NUM_REQUESTS;
            if (!fifo_empty[t]) begin
                sel     = CH_W'(t);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        do_pop = 1'b0;
        pop_ch = cur;
        if (state == IDLE) begin
            if (enabled && slot_free && sel_vld) begin
                do_pop = 1'b1;
                pop_ch = sel;
            end
        end else if (enabled && !fifo_empty[cur] && slot_free) begin
            do_pop = 1'b1;
        end
    end

    assign empties_after = (count[pop_ch] == CNT_W'(1)) && !push[pop_ch];
    assign first_rem     = (weight[sel] == '0) ? '0 : weight[sel] - 1'b1;

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            if (do_pop) begin
                out_valid <= 1'b1;
                out_q     <= '{ch: pop_ch, dat: head[pop_ch]};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (do_pop) begin
                        cur       <= sel;
                        remaining <= first_rem;
                        if (first_rem == '0 || empties_after) ptr <= next_of(sel);
                        else                                  state <= BURST;
                    end
                end
                BURST: begin
                    if (!enabled || fifo_empty[cur]) begin
                        state <= IDLE;
                        ptr   <= next_of(cur);
                    end else if (do_pop) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == WEIGHT_WIDTH'(1) || empties_after) begin
                            state <= IDLE;
                            ptr   <= next_of(cur);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data    = out_q.dat;
    assign out_channel = out_q.ch;
endmodule

// File: doc/round_robin_weighted_arbiter_n_input_1_output.md
Name: round_robin_weighted_arbiter_N_input_1_output

Overview:
- Next-generation N-to-1 arbiter for the AFU command/data paths.
- Each requester gets its own buffering FIFO with a valid/ready handshake.
- Grants are round-robin with a per-channel burst weight.
- The registered output holds data under downstream backpressure and reports which channel it came from.
- It sits between the compute-unit request streams and a single shared CAPI-facing channel.

Parameters:
- NUM_REQUESTS, 4, number of input channels (>=2).
- WIDTH, 8, payload width in bits.
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, >=2).
- WEIGHT_WIDTH, 4, width of each channel's burst-weight field.
- CH_W, $clog2(NUM_REQUESTS), width of the channel index (derived, not overridable).

Ports:
- clock  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- enabled  in  1  arbitration enable; when low no new pops occur.
- in_valid  in  NUM_REQUESTS  per-channel push request.
- in_data  in  [0:WIDTH-1] x [0:NUM_REQUESTS-1]  per-channel payload.
- in_ready  out  NUM_REQUESTS  per-channel FIFO can accept.
- weight  in  [0:WEIGHT_WIDTH-1] x [0:NUM_REQUESTS-1]  max consecutive pops per grant; 0 is treated as 1.
- out_valid  out  1  output register holds a word.
- out_data  out  [0:WIDTH-1]  output payload.
- out_channel  out  CH_W  source channel of out_data.
- out_ready  in  1  downstream accepts the word.
- fifo_empty  out  NUM_REQUESTS  per-channel FIFO empty status.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO counts and pointers go to 0; fifo_empty becomes all 1.
  - Priority pointer ptr=0, state=IDLE, remaining=0.
  - out_valid=0, out_data=0, out_channel=0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-burst or mid-handshake discards all buffered data.
- FIFO handling:
  - in_ready[i] = (count[i] < FIFO_DEPTH) & ~rst.
  - A push occurs when in_valid[i] & in_ready[i].
  - Simultaneous push and pop on the same FIFO leaves count unchanged.
  - A full FIFO deasserts in_ready even if a pop occurs in the same cycle; there is no pass-through.
- Output slot: slot_free = ~out_valid | out_ready. A pop loads out_data and out_channel and sets out_valid=1 on the same edge.
- If out_valid & out_ready with no pop, out_valid goes to 0; out_data and out_channel hold.
- Output is held stable while out_valid & ~out_ready; enabled falling never drops or clears a held word.
- FSM states: IDLE, BURST.
- IDLE:
  - Condition: enabled & slot_free & any FIFO non-empty.
  - Select the first non-empty channel scanning ptr, ptr+1, ... (mod NUM_REQUESTS) and pop it this cycle.
  - Set cur to the selected channel; remaining = max(weight[cur],1) - 1.
  - weight is sampled only here.
  - If remaining==0, or the FIFO empties after this pop: stay IDLE and set ptr=cur+1 mod N. Otherwise go to BURST.
- BURST:
  - If ~enabled, or FIFO[cur] is empty: go to IDLE, ptr=cur+1.
  - Else if slot_free: pop cur and decrement remaining.
    - If remaining becomes 0 or FIFO[cur] empties: go to IDLE, ptr=cur+1.
  - Else (backpressure): hold state and remaining.
- Latency: a push into an empty FIFO with the arbiter idle and the slot free gives out_valid 2 cycles after the push edge. Sustained throughput is 1 word/cycle while out_ready=1.
- Fairness: after a burst ends, the granted channel has the lowest priority. Channels with nothing buffered are skipped with no bubble cycle.
- ptr wraps from NUM_REQUESTS-1 to 0.
- Ordering: words from one channel leave in push order.

Test Plan:
- Reset then idle: rst held 3 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_channel=0. After release: in_ready=4'b1111, fifo_empty=4'b1111.
- Single word latency: push 8'hA5 on ch2 at cycle 0 with out_ready=1 and enabled=1 -> out_valid=1, out_data=A5, out_channel=2 at cycle 2, then out_valid=0 at cycle 3.
- Weighted round-robin: all weights 2; preload ch0..ch3 with 3 words each; out_ready=1 -> out_channel sequence 0,0,1,1,2,2,3,3,0,1,2,3 with no gaps.
- Weight zero and wrap: weight[1]=0, others 1; preload ch1 and ch3 with 2 words each -> sequence 1,3,1,3.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data/out_channel stable and no pops. FIFO fills to 4, then in_ready=0, and a 5th push is rejected. Resuming out_ready delivers the words in order.
- Enable drop and reset mid-operation:
  - enabled=0 during a burst -> the held word stays valid until accepted, no further pops; the burst terminates and ptr advances.
  - rst asserted with FIFOs full -> all FIFOs empty and out_valid=0 the next cycle.
